// File: rtl/mw_time_loader_if.sv
// mw_time_loader_if: keypad/counter-chain bus for the mm:ss time loader
interface mw_time_loader_if;
  logic       digit_valid;
  logic [3:0] digit;
  logic       start;
  logic       stop_clear;
  logic       counter_tc;
  logic       loadn;
  logic       en;
  logic [3:0] data_min_tens;
  logic [3:0] data_min_ones;
  logic [3:0] data_sec_tens;
  logic [3:0] data_sec_ones;
  logic [2:0] n_digits;
  logic       busy;
  logic       done;
  logic       err;
  modport master (
    output digit_valid, digit, start, stop_clear, counter_tc,
    input  loadn, en, data_min_tens, data_min_ones, data_sec_tens, data_sec_ones,
           n_digits, busy, done, err
  );
  modport slave (
    input  digit_valid, digit, start, stop_clear, counter_tc,
    output loadn, en, data_min_tens, data_min_ones, data_sec_tens, data_sec_ones,
           n_digits, busy, done, err
  );
endinterface

// File: rtl/mw_time_loader.sv
// mw_time_loader: keypad digit entry, one-shot load and run/pause control of a BCD mm:ss countdown
module mw_time_loader #(
  parameter int MAX_SEC_TENS = 5
) (
  input logic              clk,
  input logic              clrn,
  mw_time_loader_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, ENTRY, LOAD, RUN, PAUSE} state_t;
  state_t      state_q, state_d;
  logic [15:0] buf_q, buf_d;
  logic [2:0]  n_q, n_d;
  logic        done_q, done_d, err_q, err_d;
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    n_d     = n_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE, ENTRY: begin
        if (bus.stop_clear) begin
          state_d = IDLE;
          buf_d   = '0;
          n_d     = '0;
        end else if (bus.start) begin
          // start from IDLE or with an all-zero buffer does nothing
          if (state_q == ENTRY && buf_q != '0) begin
            if (buf_q[7:4] > 4'(MAX_SEC_TENS)) begin
              err_d   = 1'b1;
              buf_d   = '0;
              n_d     = '0;
              state_d = IDLE;
            end else begin
              state_d = LOAD;
            end
          end
        end else if (bus.digit_valid && bus.digit <= 4'd9 && n_q < 3'd4) begin
          buf_d   = {buf_q[11:0], bus.digit};
          n_d     = n_q + 3'd1;
          state_d = ENTRY;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        if (bus.counter_tc) begin
          done_d  = 1'b1;
          buf_d   = '0;
          n_d     = '0;
          state_d = IDLE;
        end else if (bus.stop_clear) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (bus.stop_clear) begin
          buf_d   = '0;
          n_d     = '0;
          state_d = IDLE;
        end else if (bus.start) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q <= IDLE;
      buf_q   <= '0;
      n_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      n_q     <= n_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  assign bus.loadn = state_q != LOAD;
  assign bus.en    = state_q == RUN;
  assign bus.busy  = state_q == LOAD || state_q == RUN || state_q == PAUSE;
  assign {bus.data_min_tens, bus.data_min_ones, bus.data_sec_tens, bus.data_sec_ones} = buf_q;
  assign bus.n_digits = n_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
endmodule
